flappy_render_score: RTL and testbench
======================================

# flappy_render_score

Parametrised per-pixel renderer, collision detector and game-state/score controller for the Flappy Bird VGA datapath. Sits between the VGA timing generator (hCount, vCount, bright) and the RGB output pins. Draws NUM_PIPES pipes plus the bird. Detects bird/pipe overlap at pixel level. Counts pipes passed and runs an IDLE/PLAY/DEAD game FSM, with all game updates committed once per frame.

## Interface
- NUM_PIPES, 2, number of pipe channels (1..8)
- PIPE_HALF_W, 50, pipe half-width in pixels
- GAP_H, 100, vertical gap height below PipeY
- BIRD_HALF, 10, bird half-size in pixels
- V_MIN, 35, first visible line (out-of-bounds check)
- V_MAX, 515, last visible line (out-of-bounds check)
- clk  in  1  pixel clock; single clock domain
- reset  in  1  synchronous, active-high reset
- bright  in  1  visible-area qualifier from VGA timing
- button  in  1  flap/start button, already debounced
- hCount, vCount  in  10 each  current pixel coordinates
- BirdX, BirdY  in  10 each  bird centre
- PipeX  in  10*NUM_PIPES  packed pipe centres; channel i is at [10i+9:10i]
- PipeY  in  10*NUM_PIPES  packed gap tops, same packing as PipeX
- rgb  out  12  registered pixel colour
- score  out  16  pipes passed in the current game
- state  out  2  game state: 0 IDLE, 1 PLAY, 2 DEAD
- collide  out  1  high while state == DEAD

## Operation
- **Arithmetic.** All geometry uses 11-bit unsigned math so that nothing wraps.
  - Left edge = PipeX < PIPE_HALF_W ? 0 : PipeX − PIPE_HALF_W.
  - Bird edges are clamped to 0 the same way.
  - Right/bottom edges = coordinate + half size, in 11 bits.
- **Pipe pixel (channel i).** left ≤ hCount ≤ right AND (vCount ≤ PipeY_i OR vCount ≥ PipeY_i + GAP_H).
- **Bird pixel.** Within ±BIRD_HALF of BirdX and BirdY, bounds inclusive.
- **Colour priority.**
  1. ~bright → 000
  2. any pipe → 0F0
  3. bird → FFF in IDLE/PLAY, F0F in DEAD
  4. otherwise → background F00
- **Frame collision flag.** Sets on any cycle where bright, bird pixel and any pipe pixel are all true. Also sets when BirdY − BIRD_HALF < V_MIN or BirdY + BIRD_HALF > V_MAX.
- **Frame boundary.** The cycle where hCount == 0 and vCount == 0.
- **Frame boundary, state PLAY:**
  - For each channel i with passed_i == 0 and PipeX_i + PIPE_HALF_W < BirdX − BIRD_HALF: set passed_i and add 1 to score.
  - If several channels qualify in one frame, add their count.
  - Score saturates at 16'hFFFF.
  - If the collision flag is set, move PLAY → DEAD. Pipes passed in the same frame are still counted.
- **passed_i clear.** passed_i clears at any frame boundary where PipeX_i > BirdX, i.e. the pipe has respawned to the right. This applies in every state.
- **Collision flag clear.** The flag clears at every frame boundary in every state. It is ignored outside PLAY.
- **Button edge.** rise = button & ~button_q, where button_q is a registered copy of button.
- **FSM transitions:**
  - IDLE, rise → PLAY. Same cycle: score ← 0, all passed ← 0, collision flag ← 0.
  - PLAY → DEAD only at a frame boundary, as above. A rise in PLAY is ignored; flapping is handled elsewhere.
  - DEAD, rise → IDLE. Score holds its value through DEAD and IDLE until the next start.
- **rise coincident with a frame boundary in IDLE.** Start wins; the boundary scoring is skipped that cycle.

## Timing
- rgb has 1-cycle latency from hCount/vCount/bright and all geometry inputs.
- score, state and collide update on the clock edge that samples the frame-boundary pixel. They are visible the next cycle.
- A button rise takes effect 1 cycle after the rising sample: 1 cycle for button_q, then the transition.
- Geometry inputs may change at any time. The collision flag covers only pixels sampled during the frame. Scoring uses the values present on the frame-boundary cycle.
- Reset values: rgb = 0, score = 0, state = IDLE, collide = 0, all passed = 0, collision flag = 0, button_q = 0.
- Reset mid-frame or mid-game discards all progress. The first frame after reset is treated like any other; no partial-frame special case.

## Test plan
- **Colour priority.** NUM_PIPES = 2, Pipe0 X = 300, Y = 200; Bird at (400, 300); bright = 1.
  - Pixel (300, 100) → rgb 0F0 one cycle later.
  - Pixel (300, 250) → F00 (inside gap).
  - Pixel (400, 300) → FFF.
  - bright = 0 → 000.
- **Start and score.** Press button in IDLE → state = 1 two cycles later, score = 0. Move Pipe0 X 400 → 330 (330 + 50 < 390). Next frame boundary → score = 1. Stays 1 on later frames until PipeX > 400, after which the pipe is scored again.
- **Simultaneous pass.** Both pipes pass in the same frame → score += 2. Repeat with score preset to 16'hFFFE via play → saturates at FFFF.
- **Collision.** Bird (300, 150) overlapping Pipe0 during PLAY → state = 2 and collide = 1 exactly at the next frame boundary. A pass in that frame still increments score. Bird pixel shows F0F.
- **Out of bounds and idle.** BirdY = 30 in PLAY → DEAD at the next boundary. The same bird positions in IDLE cause no transition.
- **Reset.** Press button in DEAD → IDLE with score held; press again → score = 0. Assert reset mid-PLAY → all outputs at reset values next cycle.

Source files
------------

// File: rtl/flappy_render_score.sv
// flappy_render_score
//   Per-pixel renderer, bird/pipe collision detector and game-state/score
//   controller for the Flappy Bird VGA datapath. It sits between the VGA timing
//   generator and the RGB pins. All game updates (scoring, PLAY->DEAD) are
//   committed on the frame-boundary pixel (hCount == 0, vCount == 0).
//
// Ports
//   clk, reset      pixel clock, synchronous active-high reset
//   bright          visible-area qualifier from the VGA timing generator
//   button          debounced flap/start button
//   hCount, vCount  current pixel coordinates
//   BirdX, BirdY    bird centre
//   PipeX, PipeY    packed pipe centres / gap tops, channel i at [10i+9:10i]
//   rgb             registered pixel colour (1-cycle latency)
//   score           pipes passed in the current game (saturating)
//   state           game state: 0 IDLE, 1 PLAY, 2 DEAD (also the FSM debug view)
//   collide         high while state == DEAD
//
// There is no valid/ready handshake: every input is sampled on every clock
// edge and every output is valid on every cycle after the edge that updates it.
module flappy_render_score #(
  parameter int NUM_PIPES   = 2,
  parameter int PIPE_HALF_W = 50,
  parameter int GAP_H       = 100,
  parameter int BIRD_HALF   = 10,
  parameter int V_MIN       = 35,
  parameter int V_MAX       = 515
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   bright,
  input  logic                   button,
  input  logic [9:0]             hCount,
  input  logic [9:0]             vCount,
  input  logic [9:0]             BirdX,
  input  logic [9:0]             BirdY,
  input  logic [10*NUM_PIPES-1:0] PipeX,
  input  logic [10*NUM_PIPES-1:0] PipeY,
  output logic [11:0]            rgb,
  output logic [15:0]            score,
  output logic [1:0]             state,
  output logic                   collide
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DEAD = 2'd2
  } gameState_t;

  localparam logic [10:0] HALF_W = 11'(PIPE_HALF_W);
  localparam logic [10:0] GAP    = 11'(GAP_H);
  localparam logic [10:0] BH     = 11'(BIRD_HALF);
  localparam logic [10:0] VMIN   = 11'(V_MIN);
  localparam logic [10:0] VMAX   = 11'(V_MAX);

  localparam logic [11:0] C_BLACK = 12'h000;
  localparam logic [11:0] C_PIPE  = 12'h0F0;
  localparam logic [11:0] C_BIRD  = 12'hFFF;
  localparam logic [11:0] C_DEADB = 12'hF0F;
  localparam logic [11:0] C_BG    = 12'hF00;

  gameState_t           stateQ, stateNext;
  logic [15:0]          scoreQ, scoreNext;
  logic [NUM_PIPES-1:0] passedQ, passedNext;
  logic                 collFlagQ, collFlagNext;
  logic                 buttonQ;
  logic [11:0]          rgbQ, rgbNext;

  // 11-bit geometry so that edge arithmetic never wraps.
  logic [10:0] h11, v11, birdX11, birdY11;
  logic [10:0] birdL, birdR, birdT, birdB;
  logic        birdPix;
  logic [NUM_PIPES-1:0] pipePix, passQual, respawn;

  assign h11     = {1'b0, hCount};
  assign v11     = {1'b0, vCount};
  assign birdX11 = {1'b0, BirdX};
  assign birdY11 = {1'b0, BirdY};

  assign birdL = (birdX11 < BH) ? 11'd0 : birdX11 - BH;
  assign birdR = birdX11 + BH;
  assign birdT = (birdY11 < BH) ? 11'd0 : birdY11 - BH;
  assign birdB = birdY11 + BH;

  assign birdPix = (h11 >= birdL) && (h11 <= birdR) &&
                   (v11 >= birdT) && (v11 <= birdB);

  for (genvar g = 0; g < NUM_PIPES; g++) begin : gPipe
    logic [10:0] px, py, pl, pr, gapBot;
    assign px     = {1'b0, PipeX[10*g +: 10]};
    assign py     = {1'b0, PipeY[10*g +: 10]};
    assign pl     = (px < HALF_W) ? 11'd0 : px - HALF_W;
    assign pr     = px + HALF_W;
    assign gapBot = py + GAP;
    assign pipePix[g]  = (h11 >= pl) && (h11 <= pr) && ((v11 <= py) || (v11 >= gapBot));
    // Pipe's right edge is fully left of the bird's left edge.
    assign passQual[g] = pr < birdL;
    // Pipe centre is right of the bird: it has respawned and may score again.
    assign respawn[g]  = px > birdX11;
  end

  logic frameBoundary, rise, outOfBounds, cycleHit, frameColl;
  assign frameBoundary = (hCount == 10'd0) && (vCount == 10'd0);
  assign rise          = button & ~buttonQ;
  assign outOfBounds   = (birdT < VMIN) || (birdB > VMAX);
  assign cycleHit      = (bright && birdPix && (|pipePix)) || outOfBounds;
  // The boundary pixel itself still belongs to the frame being closed.
  assign frameColl     = collFlagQ | cycleHit;

  // Number of channels newly passed in this frame (up to 8).
  logic [3:0]  passCnt;
  logic [16:0] scoreSum;
  logic [15:0] scoreSat;

  always_comb begin
    passCnt = 4'd0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      if (passQual[i] && !passedQ[i]) passCnt = passCnt + 4'd1;
    end
  end

  assign scoreSum = {1'b0, scoreQ} + {13'd0, passCnt};
  assign scoreSat = scoreSum[16] ? 16'hFFFF : scoreSum[15:0];

  // Next-state and game bookkeeping.
  always_comb begin
    stateNext    = stateQ;
    scoreNext    = scoreQ;
    passedNext   = passedQ;
    collFlagNext = frameColl;

    if (frameBoundary) begin
      collFlagNext = 1'b0;
      passedNext   = passedQ & ~respawn;
      if (stateQ == PLAY) begin
        passedNext = (passedQ | passQual) & ~respawn;
        scoreNext  = scoreSat;
        if (frameColl) stateNext = DEAD;
      end
    end

    // A start overrides any boundary bookkeeping in the same cycle.
    case (stateQ)
      IDLE: begin
        if (rise) begin
          stateNext    = PLAY;
          scoreNext    = 16'd0;
          passedNext   = '0;
          collFlagNext = 1'b0;
        end
      end
      DEAD: begin
        if (rise) stateNext = IDLE;
      end
      default: ;
    endcase
  end

  // Colour priority: blanking, pipes, bird, background.
  always_comb begin
    rgbNext = C_BG;
    if (!bright)           rgbNext = C_BLACK;
    else if (|pipePix)     rgbNext = C_PIPE;
    else if (birdPix)      rgbNext = (stateQ == DEAD) ? C_DEADB : C_BIRD;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ    <= IDLE;
      scoreQ    <= 16'd0;
      passedQ   <= '0;
      collFlagQ <= 1'b0;
      buttonQ   <= 1'b0;
      rgbQ      <= C_BLACK;
    end else begin
      stateQ    <= stateNext;
      scoreQ    <= scoreNext;
      passedQ   <= passedNext;
      collFlagQ <= collFlagNext;
      buttonQ   <= button;
      rgbQ      <= rgbNext;
    end
  end

  assign rgb     = rgbQ;
  assign score   = scoreQ;
  assign state   = stateQ;
  assign collide = (stateQ == DEAD);

endmodule

// File: tb/tb_flappy_render_score.sv
// Testbench for flappy_render_score: directed stimulus pushes expected values
// (with the cycle they are due) into exp_q; a negedge monitor pops and compares.
module tb_flappy_render_score;

  localparam int NP = 2;
  localparam int W  = 50;  // {due[31:0], field[1:0], value[15:0]}

  localparam logic [1:0] F_RGB   = 2'd0;
  localparam logic [1:0] F_SCORE = 2'd1;
  localparam logic [1:0] F_STATE = 2'd2;
  localparam logic [1:0] F_COLL  = 2'd3;

  logic             clk = 1'b0;
  logic             reset, bright, button;
  logic [9:0]       hCount, vCount, BirdX, BirdY;
  logic [10*NP-1:0] PipeX, PipeY;
  logic [11:0]      rgb;
  logic [15:0]      score;
  logic [1:0]       state;
  logic             collide;

  int cyc   = 0;
  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];

  flappy_render_score #(.NUM_PIPES(NP)) dut (
    .clk(clk), .reset(reset), .bright(bright), .button(button),
    .hCount(hCount), .vCount(vCount), .BirdX(BirdX), .BirdY(BirdY),
    .PipeX(PipeX), .PipeY(PipeY),
    .rgb(rgb), .score(score), .state(state), .collide(collide)
  );

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_at(input logic [1:0] f, input logic [15:0] v, input int lat);
    exp_q.push_back({32'(cyc + lat), f, v});
  endtask

  task automatic set_pipe(input int i, input int x, input int y);
    PipeX[10*i +: 10] = 10'(x);
    PipeY[10*i +: 10] = 10'(y);
  endtask

  task automatic pixel(input int h, input int v, input logic b);
    hCount = 10'(h);
    vCount = 10'(v);
    bright = b;
  endtask

  task automatic frame_nochk();
    pixel(0, 0, 1'b0);
    step();
    pixel(10, 10, 1'b0);
  endtask

  task automatic frame_chk(input logic [15:0] exp_score, input logic [1:0] exp_state);
    pixel(0, 0, 1'b0);
    expect_at(F_SCORE, exp_score, 1);
    expect_at(F_STATE, {14'd0, exp_state}, 1);
    expect_at(F_COLL, {15'd0, exp_state == 2'd2}, 1);
    step();
    pixel(10, 10, 1'b0);
  endtask

  // Button held for three cycles; the outcome is checked two cycles after press.
  task automatic press_chk(input logic [1:0] exp_state, input logic [15:0] exp_score);
    button = 1'b1;
    expect_at(F_STATE, {14'd0, exp_state}, 2);
    expect_at(F_SCORE, exp_score, 2);
    expect_at(F_COLL, {15'd0, exp_state == 2'd2}, 2);
    step(3);
    button = 1'b0;
    step();
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    logic [15:0]  act;
    int           due;
    int           idx;
    string        nm;
    idx = 0;
    while (idx < exp_q.size()) begin
      e   = exp_q[idx];
      due = int'(e[49:18]);
      if (due <= cyc) begin
        case (e[17:16])
          F_RGB:   begin act = {4'd0, rgb};     nm = "rgb";     end
          F_SCORE: begin act = score;           nm = "score";   end
          F_STATE: begin act = {14'd0, state};  nm = "state";   end
          default: begin act = {15'd0, collide}; nm = "collide"; end
        endcase
        tests++;
        if (due < cyc) begin
          fails++;
          $display("FAIL %s: check due at cycle %0d missed (now %0d)", nm, due, cyc);
        end else if (act !== e[15:0]) begin
          fails++;
          $display("FAIL %s @cycle %0d: got %h, expected %h", nm, cyc, act, e[15:0]);
        end
        exp_q.delete(idx);
      end else begin
        idx++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset  = 1'b1;
    button = 1'b0;
    BirdX  = 10'd400;
    BirdY  = 10'd300;
    PipeX  = '0;
    PipeY  = '0;
    set_pipe(0, 300, 200);
    set_pipe(1, 600, 200);
    pixel(10, 10, 1'b0);
    step(2);

    // Reset values.
    expect_at(F_RGB, 16'h000, 1);
    expect_at(F_SCORE, 16'd0, 1);
    expect_at(F_STATE, 16'd0, 1);
    expect_at(F_COLL, 16'd0, 1);
    step();
    reset = 1'b0;
    step();

    // Colour priority in IDLE.
    pixel(300, 100, 1'b1); expect_at(F_RGB, 16'h0F0, 1); step();
    pixel(300, 250, 1'b1); expect_at(F_RGB, 16'hF00, 1); step();
    pixel(400, 300, 1'b1); expect_at(F_RGB, 16'hFFF, 1); step();
    pixel(400, 300, 1'b0); expect_at(F_RGB, 16'h000, 1); step();
    pixel(10, 10, 1'b0);

    // Start, then single-pipe scoring and re-scoring after respawn.
    press_chk(2'd1, 16'd0);
    set_pipe(0, 330, 200);
    step(2);
    frame_chk(16'd1, 2'd1);
    frame_chk(16'd1, 2'd1);
    set_pipe(0, 450, 200);
    frame_chk(16'd1, 2'd1);
    set_pipe(0, 330, 200);
    frame_chk(16'd2, 2'd1);

    // Both pipes pass in the same frame.
    set_pipe(0, 450, 200);
    frame_chk(16'd2, 2'd1);
    set_pipe(0, 330, 200);
    set_pipe(1, 320, 200);
    frame_chk(16'd4, 2'd1);

    // Collision with a simultaneous pass of pipe 1.
    set_pipe(0, 450, 200);
    set_pipe(1, 600, 200);
    frame_chk(16'd4, 2'd1);
    BirdX = 10'd300;
    BirdY = 10'd150;
    set_pipe(0, 300, 200);
    set_pipe(1, 200, 200);
    pixel(300, 150, 1'b1);
    expect_at(F_RGB, 16'h0F0, 1);
    expect_at(F_STATE, 16'd1, 1);
    step();
    pixel(10, 10, 1'b0);
    expect_at(F_STATE, 16'd1, 1);
    step();
    frame_chk(16'd5, 2'd2);

    // Dead bird colour, then no further scoring in DEAD.
    set_pipe(0, 600, 200);
    set_pipe(1, 800, 200);
    pixel(300, 150, 1'b1); expect_at(F_RGB, 16'hF0F, 1); step();
    frame_chk(16'd5, 2'd2);

    // DEAD -> IDLE holds score; IDLE -> PLAY clears it.
    press_chk(2'd0, 16'd5);
    press_chk(2'd1, 16'd0);

    // Saturation: climb to FFFE two points per pass frame.
    BirdX = 10'd400;
    BirdY = 10'd300;
    for (int k = 0; k < 32766; k++) begin
      set_pipe(0, 450, 200); set_pipe(1, 600, 200); frame_nochk();
      set_pipe(0, 330, 200); set_pipe(1, 320, 200); frame_nochk();
    end
    set_pipe(0, 450, 200); set_pipe(1, 600, 200); frame_nochk();
    set_pipe(0, 330, 200); set_pipe(1, 320, 200); frame_chk(16'hFFFE, 2'd1);
    set_pipe(0, 450, 200); set_pipe(1, 600, 200); frame_nochk();
    set_pipe(0, 330, 200); set_pipe(1, 320, 200); frame_chk(16'hFFFF, 2'd1);
    set_pipe(0, 450, 200); set_pipe(1, 600, 200); frame_nochk();
    set_pipe(0, 330, 200); set_pipe(1, 320, 200); frame_chk(16'hFFFF, 2'd1);

    // Out of bounds in PLAY: death only at the boundary.
    set_pipe(0, 450, 200);
    set_pipe(1, 600, 200);
    BirdY = 10'd30;
    expect_at(F_STATE, 16'd1, 1);
    step(2);
    frame_chk(16'hFFFF, 2'd2);

    // Same hazards in IDLE cause no transition.
    press_chk(2'd0, 16'hFFFF);
    step(2);
    frame_chk(16'hFFFF, 2'd0);
    BirdX = 10'd300;
    BirdY = 10'd150;
    set_pipe(0, 300, 200);
    pixel(300, 150, 1'b1);
    step();
    frame_chk(16'hFFFF, 2'd0);

    // Reset in the middle of a game.
    BirdX = 10'd400;
    BirdY = 10'd300;
    set_pipe(0, 450, 200);
    set_pipe(1, 600, 200);
    press_chk(2'd1, 16'd0);
    set_pipe(0, 330, 200);
    frame_chk(16'd1, 2'd1);
    pixel(10, 10, 1'b1);
    expect_at(F_RGB, 16'hF00, 1);
    step();
    reset = 1'b1;
    expect_at(F_RGB, 16'h000, 1);
    expect_at(F_SCORE, 16'd0, 1);
    expect_at(F_STATE, 16'd0, 1);
    expect_at(F_COLL, 16'd0, 1);
    step();
    reset = 1'b0;
    pixel(10, 10, 1'b1);
    expect_at(F_RGB, 16'hF00, 1);
    step();
    frame_chk(16'd0, 2'd0);

    // ---------------- final report ----------------
    step(3);
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard: %0d expected values never compared", exp_q.size());
      tests += exp_q.size();
      fails += exp_q.size();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
